// File: rtl/pipeline_stall_flush_ctrl_if.sv
// pipeline_stall_flush_ctrl_if
// Bundle between the pipeline stages and the stall/flush controller.
//   master : pipeline side, drives stall_req / exc_req / exc_pc and observes
//            the controller's stall, bubble, redirect, busy and timeout outputs.
//   slave  : controller side, the mirror image of master.
interface pipeline_stall_flush_ctrl_if #(
  parameter int STAGE_NUM  = 6,
  parameter int ADDR_WIDTH = 32
);
  logic [STAGE_NUM-1:0]  stall_req;
  logic                  exc_req;
  logic [ADDR_WIDTH-1:0] exc_pc;
  logic [STAGE_NUM-1:0]  stall;
  logic [STAGE_NUM-1:0]  bubble;
  logic                  flush_pc_valid;
  logic [ADDR_WIDTH-1:0] flush_pc;
  logic                  busy;
  logic                  stall_timeout;

  modport master (
    output stall_req, exc_req, exc_pc,
    input  stall, bubble, flush_pc_valid, flush_pc, busy, stall_timeout
  );

  modport slave (
    input  stall_req, exc_req, exc_pc,
    output stall, bubble, flush_pc_valid, flush_pc, busy, stall_timeout
  );
endinterface

// File: rtl/pipeline_stall_flush_ctrl.sv
// pipeline_stall_flush_ctrl
// Per-stage stall / bubble generation plus exception flush sequencing for the
// in-order core (stage 0 = PC ... STAGE_NUM-1 = WB).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pipeline_stall_flush_ctrl_if.slave
//          in  stall_req[STAGE_NUM], exc_req, exc_pc[ADDR_WIDTH]
//          out stall[STAGE_NUM], bubble[STAGE_NUM], flush_pc_valid,
//              flush_pc[ADDR_WIDTH], busy, stall_timeout
// Optional feature: define PIPE_STALL_WATCHDOG_EN to build the stall watchdog
// (consecutive-stall counter saturating at MAX_STALL, sticky stall_timeout).
// Without it stall_timeout is tied 0.
module pipeline_stall_flush_ctrl #(
  parameter int STAGE_NUM  = 6,
  parameter int MEM_IDX    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_STALL  = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_stall_flush_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  logic [STAGE_NUM-1:0]  norm_stall;
  logic [STAGE_NUM-1:0]  stall_vec;
  logic [STAGE_NUM-1:0]  bubble_raw;
  logic [STAGE_NUM-1:0]  bubble_vec;
  logic                  flush_valid;
  logic                  busy_o;
  logic [ADDR_WIDTH-1:0] flush_pc_o;
  logic                  mem_busy;

  assign mem_busy = bus.stall_req[MEM_IDX];

  // A stall at stage H must hold every older stage behind it, so stage j is
  // stalled when any stage at or above j requests. A bubble enters stage j
  // when the stage feeding it is held but j itself moves on.
  genvar gi;
  generate
    for (gi = 0; gi < STAGE_NUM; gi++) begin : g_stage
      assign norm_stall[gi] = |bus.stall_req[STAGE_NUM-1:gi];
      if (gi == 0) begin : g_first
        assign bubble_raw[gi] = 1'b0;
      end else begin : g_rest
        assign bubble_raw[gi] = stall_vec[gi-1] & ~stall_vec[gi];
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state: exceptions are only accepted from IDLE; the handler PC is
  // captured once, so later requests while busy cannot overwrite it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.exc_req) begin
          pc_d    = bus.exc_pc;
          state_d = mem_busy ? ST_WAIT : ST_FLUSH;
        end
      end
      ST_WAIT:  if (!mem_busy) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: WAIT freezes everything up to MEM (WB may still retire);
  // FLUSH kills every stage and redirects the PC.
  always_comb begin
    stall_vec   = norm_stall;
    flush_valid = 1'b0;
    busy_o      = 1'b0;
    flush_pc_o  = '0;
    case (state_q)
      ST_WAIT: begin
        stall_vec[STAGE_NUM-2:0] = '1;
        busy_o                   = 1'b1;
      end
      ST_FLUSH: begin
        stall_vec   = '0;
        busy_o      = 1'b1;
        flush_valid = 1'b1;
        flush_pc_o  = pc_q;
      end
      default: ;
    endcase
    if (rst) stall_vec = '0;
  end

  always_comb begin
    bubble_vec = bubble_raw;
    if (state_q == ST_FLUSH) bubble_vec = '1;
    if (rst) bubble_vec = '0;
  end

  assign bus.stall          = stall_vec;
  assign bus.bubble         = bubble_vec;
  assign bus.flush_pc_valid = flush_valid;
  assign bus.flush_pc       = flush_pc_o;
  assign bus.busy           = busy_o;

`ifdef PIPE_STALL_WATCHDOG_EN
  localparam int CNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;

  // Counts consecutive cycles with any stage held; a FLUSH cycle has no
  // stall, so it both clears the count and the sticky flag.
  always_comb begin
    wd_cnt_d = '0;
    if (|stall_vec) begin
      wd_cnt_d = (wd_cnt_q == CNT_MAX) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);
    end
    timeout_d = timeout_q | (wd_cnt_d == CNT_MAX);
    if (state_q == ST_FLUSH) timeout_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.stall_timeout = timeout_q;
`else
  assign bus.stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// tb_pipeline_stall_flush_ctrl
// Directed and random stimulus for pipeline_stall_flush_ctrl, compared every
// cycle against a behavioural model (highest requesting stage, pending /
// flushing flags). Watchdog expectations follow PIPE_STALL_WATCHDOG_EN.
module tb_pipeline_stall_flush_ctrl;

  localparam int SN      = 6;
  localparam int AW      = 32;
  localparam int MAX_STL = 4;

  logic clk;
  logic rst;

  pipeline_stall_flush_ctrl_if #(.STAGE_NUM(SN), .ADDR_WIDTH(AW)) bus_if ();

  pipeline_stall_flush_ctrl #(
    .STAGE_NUM (SN),
    .MEM_IDX   (4),
    .ADDR_WIDTH(AW),
    .MAX_STALL (MAX_STL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model state
  bit          m_wait;
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_to;
  logic [5:0]  e_stall;
  logic [5:0]  e_bubble;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_wait  = 1'b0;
    m_flush = 1'b0;
    m_pc    = '0;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  task automatic compute_expect();
    int h;
    h = -1;
    for (int i = 0; i < SN; i++) if (bus_if.stall_req[i]) h = i;
    e_stall = (h < 0) ? 6'd0 : 6'((1 << (h + 1)) - 1);
    if (m_wait)  e_stall = e_stall | 6'b011111;
    if (m_flush) e_stall = 6'd0;
    e_bubble = 6'd0;
    for (int j = 1; j < SN; j++) e_bubble[j] = e_stall[j-1] & ~e_stall[j];
    if (m_flush) e_bubble = 6'b111111;
    if (rst) begin
      e_stall  = 6'd0;
      e_bubble = 6'd0;
    end
  endtask

  task automatic settle(input string tag);
    logic exp_to;
    #2;
    if (rst) model_reset();
    compute_expect();
`ifdef PIPE_STALL_WATCHDOG_EN
    exp_to = m_to;
`else
    exp_to = 1'b0;
`endif
    chk({tag, ".stall"},  32'(bus_if.stall),          32'(e_stall));
    chk({tag, ".bubble"}, 32'(bus_if.bubble),         32'(e_bubble));
    chk({tag, ".fpv"},    32'(bus_if.flush_pc_valid), 32'(m_flush));
    chk({tag, ".fpc"},    bus_if.flush_pc,            m_flush ? m_pc : 32'd0);
    chk({tag, ".busy"},   32'(bus_if.busy),           32'(m_wait | m_flush));
    chk({tag, ".tmo"},    32'(bus_if.stall_timeout),  32'(exp_to));
  endtask

  task automatic tick(input string tag, input bit verbose);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      compute_expect();
      m_cnt = (|e_stall) ? ((m_cnt >= MAX_STL) ? MAX_STL : m_cnt + 1) : 0;
      m_to  = m_flush ? 1'b0 : (m_to | (m_cnt == MAX_STL));
      if (m_flush) begin
        m_flush = 1'b0;
      end else if (m_wait) begin
        if (!bus_if.stall_req[4]) begin
          m_wait  = 1'b0;
          m_flush = 1'b1;
        end
      end else if (bus_if.exc_req) begin
        m_pc = bus_if.exc_pc;
        if (bus_if.stall_req[4]) m_wait = 1'b1;
        else                     m_flush = 1'b1;
      end
    end
    if (verbose)
      $display("[%0t] %s sreq=%b exc=%b stall=%b bubble=%b fpv=%b busy=%b", $time, tag,
               bus_if.stall_req, bus_if.exc_req, bus_if.stall, bus_if.bubble,
               bus_if.flush_pc_valid, bus_if.busy);
    #1;
  endtask

  initial begin
    model_reset();
    rst              = 1'b0;
    bus_if.stall_req = '0;
    bus_if.exc_req   = 1'b0;
    bus_if.exc_pc    = '0;
    #1 rst = 1'b1;

    // Reset state
    settle("reset");
    tick("reset", 1'b1);
    settle("reset2");
    tick("reset2", 1'b1);
    rst = 1'b0;
    settle("idle");
    tick("idle", 1'b1);

    // ID-only stall
    bus_if.stall_req = 6'b000100;
    settle("id_stall");
    chk("id_stall_lit.stall",  32'(bus_if.stall),  32'h07);
    chk("id_stall_lit.bubble", 32'(bus_if.bubble), 32'h08);
    tick("id_stall", 1'b1);

    // Multiple requests, then WB
    bus_if.stall_req = 6'b010100;
    settle("multi");
    chk("multi_lit.stall",  32'(bus_if.stall),  32'h1F);
    chk("multi_lit.bubble", 32'(bus_if.bubble), 32'h20);
    tick("multi", 1'b1);
    bus_if.stall_req = 6'b100000;
    settle("wb");
    chk("wb_lit.stall",  32'(bus_if.stall),  32'h3F);
    chk("wb_lit.bubble", 32'(bus_if.bubble), 32'h00);
    tick("wb", 1'b1);

    // Exception with MEM idle
    bus_if.stall_req = '0;
    bus_if.exc_req   = 1'b1;
    bus_if.exc_pc    = 32'hBFC00380;
    settle("exc_idle");
    tick("exc_idle", 1'b1);
    bus_if.exc_req = 1'b0;
    settle("exc_flush");
    chk("exc_flush_lit.fpv",    32'(bus_if.flush_pc_valid), 32'd1);
    chk("exc_flush_lit.fpc",    bus_if.flush_pc,            32'hBFC00380);
    chk("exc_flush_lit.bubble", 32'(bus_if.bubble),         32'h3F);
    chk("exc_flush_lit.stall",  32'(bus_if.stall),          32'h00);
    tick("exc_flush", 1'b1);
    settle("exc_after");
    chk("exc_after_lit.busy", 32'(bus_if.busy), 32'd0);
    tick("exc_after", 1'b1);

    // Exception with MEM busy 3 cycles; second request during WAIT ignored
    bus_if.stall_req = 6'b010000;
    bus_if.exc_req   = 1'b1;
    bus_if.exc_pc    = 32'h8000_0100;
    settle("memb_acc");
    tick("memb_acc", 1'b1);
    bus_if.exc_pc = 32'h0000_1234;
    for (int k = 0; k < 2; k++) begin
      settle("memb_wait");
      chk("memb_wait_lit.stall", 32'(bus_if.stall[4:0]), 32'h1F);
      chk("memb_wait_lit.busy",  32'(bus_if.busy),       32'd1);
      tick("memb_wait", 1'b1);
    end
    bus_if.stall_req = '0;
    settle("memb_rel");
    chk("memb_rel_lit.fpv", 32'(bus_if.flush_pc_valid), 32'd0);
    tick("memb_rel", 1'b1);
    bus_if.exc_req = 1'b0;
    settle("memb_flush");
    chk("memb_flush_lit.fpv", 32'(bus_if.flush_pc_valid), 32'd1);
    chk("memb_flush_lit.fpc", bus_if.flush_pc,            32'h8000_0100);
    tick("memb_flush", 1'b1);
    settle("memb_done");
    tick("memb_done", 1'b1);

    // Reset mid-WAIT
    bus_if.stall_req = 6'b010000;
    bus_if.exc_req   = 1'b1;
    bus_if.exc_pc    = 32'hDEAD_0000;
    settle("rw_acc");
    tick("rw_acc", 1'b1);
    bus_if.exc_req = 1'b0;
    settle("rw_wait");
    chk("rw_wait_lit.busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    settle("rw_rst");
    chk("rw_rst_lit.busy",  32'(bus_if.busy),  32'd0);
    chk("rw_rst_lit.stall", 32'(bus_if.stall), 32'd0);
    tick("rw_rst", 1'b1);
    rst              = 1'b0;
    bus_if.stall_req = '0;
    for (int k = 0; k < 3; k++) begin
      settle("rw_post");
      chk("rw_post_lit.fpv", 32'(bus_if.flush_pc_valid), 32'd0);
      tick("rw_post", 1'b1);
    end

    // Watchdog: long ID stall, release, then an exception flush
    bus_if.stall_req = 6'b000100;
    for (int k = 0; k < 6; k++) begin
      settle("wd_hold");
      tick("wd_hold", 1'b1);
    end
`ifdef PIPE_STALL_WATCHDOG_EN
    chk("wd_lit.tmo_set", 32'(bus_if.stall_timeout), 32'd1);
`else
    chk("wd_lit.tmo_off", 32'(bus_if.stall_timeout), 32'd0);
`endif
    bus_if.stall_req = '0;
    settle("wd_rel");
    tick("wd_rel", 1'b1);
    bus_if.exc_req = 1'b1;
    bus_if.exc_pc  = 32'h0000_0200;
    settle("wd_exc");
    tick("wd_exc", 1'b1);
    bus_if.exc_req = 1'b0;
    settle("wd_flush");
    tick("wd_flush", 1'b1);
    settle("wd_clr");
    chk("wd_lit.tmo_clr", 32'(bus_if.stall_timeout), 32'd0);
    tick("wd_clr", 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst              = ($urandom_range(0, 99) == 0);
      bus_if.stall_req = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
      bus_if.exc_req   = ($urandom_range(0, 3) == 0);
      bus_if.exc_pc    = $urandom;
      settle("rand");
      tick("rand", 1'b0);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
